// File: rtl/wb_merge_if.sv
// Writeback merge bus: ALU and load result streams in, regfile write port and status out.
// The slave modport is the merge stage; the master modport drives it.
interface wb_merge_if #(
  parameter int unsigned DATAPATH_WIDTH     = 64,
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned LD_FIFO_DEPTH      = 4
);
  localparam int unsigned CntW = $clog2(LD_FIFO_DEPTH) + 1;

  logic                          alu_valid;
  logic                          alu_ready;
  logic [REGFILE_ADDR_WIDTH-1:0] alu_addr;
  logic [DATAPATH_WIDTH-1:0]     alu_data;

  logic                          ld_valid;
  logic                          ld_ready;
  logic [REGFILE_ADDR_WIDTH-1:0] ld_addr;
  logic [DATAPATH_WIDTH-1:0]     ld_data;

  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out;
  logic [DATAPATH_WIDTH-1:0]     WR_data_out;
  logic                          wena_out;
  logic [CntW-1:0]               ld_pending;

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready, WR_addr_out, WR_data_out, wena_out, ld_pending
  );

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready, WR_addr_out, WR_data_out, wena_out, ld_pending
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge stage: arbitrates ALU results and buffered load responses onto a
// single registered regfile write port.
module wb_merge #(
  parameter int unsigned DATAPATH_WIDTH     = 64,
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned LD_FIFO_DEPTH      = 4
) (
  input logic        clk,
  input logic        reset,
  wb_merge_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(LD_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(LD_FIFO_DEPTH);

  typedef logic [REGFILE_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATAPATH_WIDTH-1:0]     data_t;

  // Load FIFO storage; pointers and count carry the reset, storage does not need to.
  addr_t           fifo_addr_q [LD_FIFO_DEPTH];
  data_t           fifo_data_q [LD_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  addr_t wr_addr_q, wr_addr_d;
  data_t wr_data_q, wr_data_d;
  logic  wena_q, wena_d;

  logic  fifo_full, fifo_empty;
  logic  sel_alu, sel_ld, sel_any;
  logic  push, pop;
  addr_t sel_addr;
  data_t sel_data;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);

  // Priority: full FIFO drains first, then ALU, then any buffered load.
  always_comb begin
    sel_alu = 1'b0;
    sel_ld  = 1'b0;
    if (fifo_full) begin
      sel_ld = 1'b1;
    end else if (bus.alu_valid) begin
      sel_alu = 1'b1;
    end else if (!fifo_empty) begin
      sel_ld = 1'b1;
    end
  end

  assign sel_any = sel_alu || sel_ld;
  assign push    = bus.ld_valid && !fifo_full;
  assign pop     = sel_ld;

  always_comb begin
    sel_addr = fifo_addr_q[rd_ptr_q];
    sel_data = fifo_data_q[rd_ptr_q];
    if (sel_alu) begin
      sel_addr = bus.alu_addr;
      sel_data = bus.alu_data;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wena_d    = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Register 0 results are consumed but never written.
    if (sel_any) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wena_d    = (sel_addr != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wena_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wena_q    <= wena_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.ld_addr;
      fifo_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end

  assign bus.alu_ready   = !fifo_full;
  assign bus.ld_ready    = !fifo_full;
  assign bus.WR_addr_out = wr_addr_q;
  assign bus.WR_data_out = wr_data_q;
  assign bus.wena_out    = wena_q;
  assign bus.ld_pending  = count_q;

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: per-stream expected-write queues checked against every
// regfile write, plus directed timing/occupancy checks.
module tb_wb_merge;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int D  = 4;

  typedef logic [AW+DW-1:0] wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_merge_if #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .LD_FIFO_DEPTH(D)) bus ();

  wb_merge #(
    .DATAPATH_WIDTH    (DW),
    .REGFILE_ADDR_WIDTH(AW),
    .LD_FIFO_DEPTH     (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t  alu_q[$];
  wr_t  ld_q[$];
  int   checks = 0;
  int   errors = 0;
  logic alu_acc, ld_acc;
  logic wena_seen;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t got, exp;
    chk("pending_bound", 80'(bus.ld_pending <= 3'd4), 80'(1));
    if (bus.wena_out) begin
      wena_seen = 1'b1;
      got = {bus.WR_addr_out, bus.WR_data_out};
      if (alu_q.size() > 0 && alu_q[0] === got) exp = alu_q.pop_front();
      else if (ld_q.size() > 0) exp = ld_q.pop_front();
      else if (alu_q.size() > 0) exp = alu_q.pop_front();
      else exp = 'x;
      chk("wr_scoreboard", 80'(got), 80'(exp));
    end
  endtask

  // One clock: record handshakes before the edge, check outputs just after it.
  task automatic cycle();
    @(negedge clk);
    alu_acc = bus.alu_valid && bus.alu_ready;
    ld_acc  = bus.ld_valid && bus.ld_ready;
    if (alu_acc && bus.alu_addr != '0) alu_q.push_back({bus.alu_addr, bus.alu_data});
    if (ld_acc && bus.ld_addr != '0) ld_q.push_back({bus.ld_addr, bus.ld_data});
    @(posedge clk);
    #1;
    monitor();
  endtask

  initial begin
    int   a;
    logic done;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    wena_seen     = 1'b0;
    reset         = 1'b0;
    #1 reset = 1'b1;
    #12;
    chk("rst_wena", 80'(bus.wena_out), 80'(0));
    chk("rst_addr", 80'(bus.WR_addr_out), 80'(0));
    chk("rst_data", 80'(bus.WR_data_out), 80'(0));
    chk("rst_pending", 80'(bus.ld_pending), 80'(0));
    chk("rst_ld_ready", 80'(bus.ld_ready), 80'(1));
    chk("rst_alu_ready", 80'(bus.alu_ready), 80'(1));
    reset = 1'b0;
    cycle();
    cycle();

    // ALU passthrough
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 64'hDEAD_BEEF_0000_0001;
    cycle();
    chk("alu_wena", 80'(bus.wena_out), 80'(1));
    chk("alu_addr", 80'(bus.WR_addr_out), 80'(5));
    chk("alu_data", 80'(bus.WR_data_out), 80'(64'hDEAD_BEEF_0000_0001));
    bus.alu_valid = 1'b0;
    cycle();
    chk("alu_wena_off", 80'(bus.wena_out), 80'(0));
    chk("alu_addr_hold", 80'(bus.WR_addr_out), 80'(5));

    // Load drain in an idle slot
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 5'd7;
    bus.ld_data  = 64'h1234;
    cycle();
    chk("ld_pending_push", 80'(bus.ld_pending), 80'(1));
    chk("ld_wena_early", 80'(bus.wena_out), 80'(0));
    bus.ld_valid = 1'b0;
    cycle();
    chk("ld_wena", 80'(bus.wena_out), 80'(1));
    chk("ld_addr", 80'(bus.WR_addr_out), 80'(7));
    chk("ld_data", 80'(bus.WR_data_out), 80'(64'h1234));
    chk("ld_pending_drain", 80'(bus.ld_pending), 80'(0));

    // Contention: ALU busy every cycle while four loads arrive
    a = 1;
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.alu_addr = 5'(a);
      bus.alu_data = {$urandom, $urandom};
      bus.ld_addr  = 5'(10 + k);
      bus.ld_data  = {$urandom, $urandom};
      cycle();
      if (alu_acc) a++;
    end
    bus.ld_valid = 1'b0;
    bus.alu_addr = 5'(a);
    bus.alu_data = {$urandom, $urandom};
    chk("full_pending", 80'(bus.ld_pending), 80'(4));
    chk("full_ld_ready", 80'(bus.ld_ready), 80'(0));
    chk("full_alu_ready", 80'(bus.alu_ready), 80'(0));
    cycle();
    chk("full_alu_stalled", 80'(alu_acc), 80'(0));
    chk("full_drain_addr", 80'(bus.WR_addr_out), 80'(10));
    chk("full_drain_wena", 80'(bus.wena_out), 80'(1));
    chk("full_alu_ready_back", 80'(bus.alu_ready), 80'(1));
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("busy_alu_acc", 80'(alu_acc), 80'(1));
      chk("busy_pending", 80'(bus.ld_pending), 80'(3));
      a++;
      bus.alu_addr = 5'(a);
      bus.alu_data = {$urandom, $urandom};
    end
    bus.alu_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cycle();
      chk("drain_addr", 80'(bus.WR_addr_out), 80'(10 + k));
    end
    chk("drain_pending", 80'(bus.ld_pending), 80'(0));
    cycle();

    // Register 0 results are consumed silently
    wena_seen     = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = '0;
    bus.alu_data  = 64'hFFFF;
    cycle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = '0;
    bus.ld_data   = 64'hFFFF;
    cycle();
    bus.ld_valid = 1'b0;
    chk("r0_pending", 80'(bus.ld_pending), 80'(1));
    cycle();
    cycle();
    chk("r0_pending_drain", 80'(bus.ld_pending), 80'(0));
    chk("r0_no_wena", 80'(wena_seen), 80'(0));

    // Wrap-around: nine loads with ALU bursts and idle gaps
    for (int i = 0; i < 9; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 5'(16 + i);
      bus.ld_data   = {$urandom, $urandom};
      bus.alu_valid = (i % 3 != 2);
      bus.alu_addr  = 5'(26 + (i % 4));
      bus.alu_data  = {$urandom, $urandom};
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        cycle();
        done = ld_acc;
      end
      chk("wrap_ld_accept", 80'(done), 80'(1));
      bus.ld_valid  = 1'b0;
      bus.alu_valid = 1'b0;
      if (i % 2 == 1) cycle();
    end
    for (int t = 0; t < 10; t++) cycle();
    chk("wrap_pending", 80'(bus.ld_pending), 80'(0));
    chk("wrap_ld_q_empty", 80'(ld_q.size()), 80'(0));
    chk("wrap_alu_q_empty", 80'(alu_q.size()), 80'(0));

    // Asynchronous reset mid-cycle with three loads buffered behind a busy ALU
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.alu_addr = 5'(20);
      bus.alu_data = {$urandom, $urandom};
      bus.ld_addr  = 5'(21 + k);
      bus.ld_data  = {$urandom, $urandom};
      cycle();
    end
    chk("pre_rst_pending", 80'(bus.ld_pending), 80'(3));
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wena", 80'(bus.wena_out), 80'(0));
    chk("async_rst_pending", 80'(bus.ld_pending), 80'(0));
    chk("async_rst_ld_ready", 80'(bus.ld_ready), 80'(1));
    chk("async_rst_alu_ready", 80'(bus.alu_ready), 80'(1));
    alu_q.delete();
    ld_q.delete();
    wena_seen = 1'b0;
    cycle();
    reset = 1'b0;
    for (int t = 0; t < 8; t++) cycle();
    chk("post_rst_no_write", 80'(wena_seen), 80'(0));
    chk("post_rst_pending", 80'(bus.ld_pending), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
